// File: rtl/symbol_serializer_fifo_pkg.sv
`default_nettype none
//============================================================================
// Package     : symbol_serializer_fifo_pkg
// Description : Shared default geometry for the symbol serializer FIFO.
// Revision    : 1.0 - initial release
//============================================================================
package symbol_serializer_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_BIT_IDX_W  = $clog2(DEF_DATA_WIDTH);

endpackage : symbol_serializer_fifo_pkg
`default_nettype wire

// File: rtl/symbol_serializer_fifo_mem.sv
`default_nettype none
//============================================================================
// Module      : symbol_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, synchronous write and
//               asynchronous read of the head entry.
// Revision    : 1.0 - initial release
//============================================================================
module symbol_fifo_mem
    import symbol_serializer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_writeEnable,
    input  logic [ADDR_WIDTH-1:0] i_writeAddr,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    input  logic [ADDR_WIDTH-1:0] i_readAddr,
    output logic [DATA_WIDTH-1:0] o_readData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents are intentionally left uninitialised on reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_writeEnable) begin
            r_mem[i_writeAddr] <= i_writeData;
        end
    end

    assign o_readData = r_mem[i_readAddr];

endmodule : symbol_fifo_mem
`default_nettype wire

// File: rtl/symbol_serializer_fifo.sv
`default_nettype none
//============================================================================
// Module      : symbol_serializer_fifo
// Description : Symbol-wide write, bit-serial read FIFO for the transmit path.
//               Define SYMBOL_LSB_FIRST_EN to shift symbols out LSB first.
// Revision    : 1.0 - initial release
//============================================================================
module symbol_serializer_fifo
    import symbol_serializer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                          inClock,
    input  logic                          inReset,
    input  logic                          inWriteEnable,
    input  logic [DATA_WIDTH-1:0]         inData,
    input  logic                          inReadEnable,
    output logic                          outData,
    output logic                          outValid,
    output logic                          outDone,
    output logic [ADDR_WIDTH:0]           outWriteCount,
    output logic [$clog2(DATA_WIDTH)-1:0] outReadCount,
    output logic                          outFull,
    output logic                          outEmpty,
    output logic                          outAlmostFull,
    output logic                          outAlmostEmpty,
    output logic                          outWriteError,
    output logic                          outReadError
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int BIT_IDX_W = $clog2(DATA_WIDTH);

    localparam logic [ADDR_WIDTH:0]   c_FULL_CNT   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_AFULL_CNT  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [BIT_IDX_W-1:0]  c_BIT_ONE    = BIT_IDX_W'(1);
    localparam logic [BIT_IDX_W-1:0]  c_LAST_BIT   = BIT_IDX_W'(DATA_WIDTH - 1);

    logic [ADDR_WIDTH-1:0] r_writePtr;
    logic [ADDR_WIDTH-1:0] r_readPtr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [BIT_IDX_W-1:0]  r_bitIdx;
    logic                  r_data;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_writeError;
    logic                  r_readError;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_doWrite;
    logic                  w_doRead;
    logic                  w_symbolDone;
    logic [DATA_WIDTH-1:0] w_headSymbol;
    logic [BIT_IDX_W-1:0]  w_bitSel;
    logic                  w_headBit;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_doWrite    = inWriteEnable && !w_full;
    assign w_doRead     = inReadEnable && !w_empty;
    assign w_symbolDone = w_doRead && (r_bitIdx == c_LAST_BIT);

    symbol_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk           (inClock),
        .i_writeEnable (w_doWrite),
        .i_writeAddr   (r_writePtr),
        .i_writeData   (inData),
        .i_readAddr    (r_readPtr),
        .o_readData    (w_headSymbol)
    );

`ifdef SYMBOL_LSB_FIRST_EN
    assign w_bitSel = r_bitIdx;
`else
    assign w_bitSel = c_LAST_BIT - r_bitIdx;
`endif

    assign w_headBit = w_headSymbol[w_bitSel];

    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_writePtr   <= '0;
            r_readPtr    <= '0;
            r_count      <= '0;
            r_bitIdx     <= '0;
            r_data       <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_writeError <= 1'b0;
            r_readError  <= 1'b0;
        end else begin
            r_valid      <= w_doRead;
            r_done       <= w_symbolDone;
            r_writeError <= inWriteEnable && w_full;
            r_readError  <= inReadEnable && w_empty;

            if (w_doWrite) begin
                r_writePtr <= r_writePtr + c_PTR_ONE;
            end

            if (w_doRead) begin
                r_data <= w_headBit;
                if (w_symbolDone) begin
                    r_bitIdx  <= '0;
                    r_readPtr <= r_readPtr + c_PTR_ONE;
                end else begin
                    r_bitIdx  <= r_bitIdx + c_BIT_ONE;
                end
            end

            // A write and a symbol-completing read in one cycle cancel out.
            case ({w_doWrite, w_symbolDone})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign outData        = r_data;
    assign outValid       = r_valid;
    assign outDone        = r_done;
    assign outWriteCount  = r_count;
    assign outReadCount   = r_bitIdx;
    assign outFull        = w_full;
    assign outEmpty       = w_empty;
    assign outAlmostFull  = (r_count >= c_AFULL_CNT);
    assign outAlmostEmpty = (r_count <= c_CNT_ONE);
    assign outWriteError  = r_writeError;
    assign outReadError   = r_readError;

endmodule : symbol_serializer_fifo
`default_nettype wire

// File: tb/tb_symbol_serializer_fifo.sv
`default_nettype none
//============================================================================
// Module      : tb_symbol_serializer_fifo
// Description : Directed vector bench for symbol_serializer_fifo (4-bit
//               symbols, depth 4).
// Revision    : 1.0 - initial release
//============================================================================
module tb_symbol_serializer_fifo;

    logic       inClock = 1'b0;
    logic       inReset = 1'b1;
    logic       inWriteEnable = 1'b0;
    logic [3:0] inData = 4'h0;
    logic       inReadEnable = 1'b0;
    logic       outData, outValid, outDone;
    logic [2:0] outWriteCount;
    logic [1:0] outReadCount;
    logic       outFull, outEmpty, outAlmostFull, outAlmostEmpty;
    logic       outWriteError, outReadError;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [3:0]  d;
        logic        re;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    symbol_serializer_fifo dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inWriteEnable  (inWriteEnable),
        .inData         (inData),
        .inReadEnable   (inReadEnable),
        .outData        (outData),
        .outValid       (outValid),
        .outDone        (outDone),
        .outWriteCount  (outWriteCount),
        .outReadCount   (outReadCount),
        .outFull        (outFull),
        .outEmpty       (outEmpty),
        .outAlmostFull  (outAlmostFull),
        .outAlmostEmpty (outAlmostEmpty),
        .outWriteError  (outWriteError),
        .outReadError   (outReadError)
    );

    always #5 inClock = ~inClock;

    // Expected output word; flags follow from the symbol count (depth 4).
    function automatic logic [13:0] pack(input int data, input int valid, input int done,
                                         input int cnt, input int rc, input int werr,
                                         input int rerr);
        logic full, empty, aFull, aEmpty;
        full   = (cnt == 4);
        empty  = (cnt == 0);
        aFull  = (cnt >= 3);
        aEmpty = (cnt <= 1);
        return {1'(data), 1'(valid), 1'(done), 3'(cnt), 2'(rc),
                full, empty, aFull, aEmpty, 1'(werr), 1'(rerr)};
    endfunction

    task automatic add(input int we, input int d, input int re, input int data,
                       input int valid, input int done, input int cnt, input int rc,
                       input int werr, input int rerr);
        vec_t v;
        v.we  = 1'(we);
        v.d   = 4'(d);
        v.re  = 1'(re);
        v.exp = pack(data, valid, done, cnt, rc, werr, rerr);
        vecs.push_back(v);
    endtask

    task automatic step(input logic rst, input logic we, input logic [3:0] d, input logic re);
        inReset       = rst;
        inWriteEnable = we;
        inData        = d;
        inReadEnable  = re;
        @(posedge inClock);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {outData, outValid, outDone, outWriteCount, outReadCount,
               outFull, outEmpty, outAlmostFull, outAlmostEmpty,
               outWriteError, outReadError};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (data,valid,done,wcnt,rcnt,full,empty,af,ae,werr,rerr)",
                     name, act, exp);
        end
    endtask

    initial begin
        // Fields: we, d, re | data, valid, done, wcnt, rcnt, werr, rerr
`ifndef SYMBOL_LSB_FIRST_EN
        add(0, 0,   0,  0,0,0,0,0,0,0);
        add(1, 'hA, 0,  0,0,0,1,0,0,0);
        add(1, 'hD, 0,  0,0,0,2,0,0,0);
        add(1, 'h7, 0,  0,0,0,3,0,0,0);
        add(1, 'hF, 0,  0,0,0,4,0,0,0);
        add(0, 0, 1,  1,1,0,4,1,0,0);  // 0xA = 1010
        add(0, 0, 1,  0,1,0,4,2,0,0);
        add(0, 0, 1,  1,1,0,4,3,0,0);
        add(0, 0, 1,  0,1,1,3,0,0,0);
        add(0, 0, 1,  1,1,0,3,1,0,0);  // 0xD = 1101
        add(0, 0, 1,  1,1,0,3,2,0,0);
        add(0, 0, 1,  0,1,0,3,3,0,0);
        add(0, 0, 1,  1,1,1,2,0,0,0);
        add(0, 0, 1,  0,1,0,2,1,0,0);  // 0x7 = 0111
        add(0, 0, 1,  1,1,0,2,2,0,0);
        add(0, 0, 1,  1,1,0,2,3,0,0);
        add(0, 0, 1,  1,1,1,1,0,0,0);
        add(0, 0, 1,  1,1,0,1,1,0,0);  // 0xF = 1111
        add(0, 0, 1,  1,1,0,1,2,0,0);
        add(0, 0, 1,  1,1,0,1,3,0,0);
        add(0, 0, 1,  1,1,1,0,0,0,0);
        add(0, 0, 1,  1,0,0,0,0,0,1);  // read while empty
        add(0, 0, 0,  1,0,0,0,0,0,0);
        add(1, 'h6, 1, 1,0,0,1,0,0,1); // write lands, read still errors
        add(0, 0, 1,  0,1,0,1,1,0,0);  // 0x6 = 0110
        add(0, 0, 1,  1,1,0,1,2,0,0);
        add(0, 0, 1,  1,1,0,1,3,0,0);
        add(0, 0, 1,  0,1,1,0,0,0,0);
        add(1, 'h1, 0, 0,0,0,1,0,0,0);
        add(1, 'h2, 0, 0,0,0,2,0,0,0);
        add(1, 'h4, 0, 0,0,0,3,0,0,0);
        add(1, 'h8, 0, 0,0,0,4,0,0,0);
        add(1, 'hF, 0, 0,0,0,4,0,1,0); // overflow rejected
        add(0, 0, 0,  0,0,0,4,0,0,0);
        add(1, 'hE, 1, 0,1,0,4,1,1,0); // still full: write rejected, read proceeds
        add(0, 0, 1,  0,1,0,4,2,0,0);
        add(0, 0, 1,  0,1,0,4,3,0,0);
        add(0, 0, 1,  1,1,1,3,0,0,0);
        add(0, 0, 1,  0,1,0,3,1,0,0);  // 0x2 = 0010
        add(0, 0, 1,  0,1,0,3,2,0,0);
        add(0, 0, 1,  1,1,0,3,3,0,0);
        add(0, 0, 1,  0,1,1,2,0,0,0);
        add(0, 0, 1,  0,1,0,2,1,0,0);  // 0x4 = 0100
        add(0, 0, 1,  1,1,0,2,2,0,0);
        add(0, 0, 1,  0,1,0,2,3,0,0);
        add(0, 0, 1,  0,1,1,1,0,0,0);
        add(0, 0, 1,  1,1,0,1,1,0,0);  // 0x8 = 1000
        add(0, 0, 1,  0,1,0,1,2,0,0);
        add(0, 0, 1,  0,1,0,1,3,0,0);
        add(0, 0, 1,  0,1,1,0,0,0,0);
        add(0, 0, 1,  0,0,0,0,0,0,1);  // fifth symbol never stored
        add(1, 'h3, 0, 0,0,0,1,0,0,0);
        add(0, 0, 1,  0,1,0,1,1,0,0);  // 0x3 = 0011
        add(0, 0, 1,  0,1,0,1,2,0,0);
        add(0, 0, 1,  1,1,0,1,3,0,0);
        add(1, 'h5, 1, 1,1,1,1,0,0,0); // write with completing read
        add(0, 0, 1,  0,1,0,1,1,0,0);  // 0x5 = 0101
        add(0, 0, 1,  1,1,0,1,2,0,0);
        add(0, 0, 1,  0,1,0,1,3,0,0);
        add(0, 0, 1,  1,1,1,0,0,0,0);
`else
        add(0, 0,   0,  0,0,0,0,0,0,0);
        add(1, 'hA, 0,  0,0,0,1,0,0,0);
        add(1, 'h3, 0,  0,0,0,2,0,0,0);
        add(0, 0, 1,  0,1,0,2,1,0,0);  // 0xA LSB first: 0,1,0,1
        add(0, 0, 1,  1,1,0,2,2,0,0);
        add(0, 0, 1,  0,1,0,2,3,0,0);
        add(0, 0, 1,  1,1,1,1,0,0,0);
        add(0, 0, 1,  1,1,0,1,1,0,0);  // 0x3 LSB first: 1,1,0,0
        add(0, 0, 1,  1,1,0,1,2,0,0);
        add(0, 0, 1,  0,1,0,1,3,0,0);
        add(0, 0, 1,  0,1,1,0,0,0,0);
        add(1, 'h8, 0,  0,0,0,1,0,0,0);
        add(0, 0, 1,  0,1,0,1,1,0,0);  // 0x8 LSB first: 0,0,0,1
        add(0, 0, 1,  0,1,0,1,2,0,0);
        add(0, 0, 1,  0,1,0,1,3,0,0);
        add(0, 0, 1,  1,1,1,0,0,0,0);
`endif

        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check("reset_state", pack(0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].we, vecs[i].d, vecs[i].re);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of a symbol discards it; outData was left at 1.
        step(1'b0, 1'b1, 4'hC, 1'b0);
        check("mid_wr_c", pack(1,0,0,1,0,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
`ifndef SYMBOL_LSB_FIRST_EN
        check("mid_rd1", pack(1,1,0,1,1,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("mid_rd2", pack(1,1,0,1,2,0,0));
`else
        check("mid_rd1", pack(0,1,0,1,1,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("mid_rd2", pack(0,1,0,1,2,0,0));
`endif
        step(1'b1, 1'b0, 4'h0, 1'b0);
        check("mid_reset", pack(0,0,0,0,0,0,0));
        step(1'b0, 1'b1, 4'h9, 1'b0);
        check("post_wr_9", pack(0,0,0,1,0,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_rd1", pack(1,1,0,1,1,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_rd2", pack(0,1,0,1,2,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_rd3", pack(0,1,0,1,3,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_rd4", pack(1,1,1,0,0,0,0));
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check("post_idle", pack(1,0,0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_symbol_serializer_fifo
`default_nettype wire

// File: doc/symbol_serializer_fifo.md
# symbol_serializer_fifo

Transmit-side counterpart of the receive bit-collecting FIFO: it accepts DATA_WIDTH-bit symbols on a parallel write port, buffers up to 2^ADDR_WIDTH of them, and emits them one bit per read request on a serial output. It sits between the symbol source (spreading/modulator feed) and the bit-serial transmit path of the Zigbee chain. Status, count and error outputs mirror the receive FIFO's.

## Interface
- DATA_WIDTH, 4: symbol width in bits (power of two, ≥2).
- ADDR_WIDTH, 2: FIFO address width; depth DEPTH = 2^ADDR_WIDTH symbols.
- inClock  in  1  rising-edge clock.
- inReset  in  1  reset; one clock, synchronous, active-high.
- inWriteEnable  in  1  push inData as one symbol.
- inData  in  DATA_WIDTH  symbol to push.
- inReadEnable  in  1  request the next serial bit.
- outData  out  1  registered serial bit.
- outValid  out  1  pulse, outData updated this cycle.
- outDone  out  1  pulse with the last bit of a symbol.
- outWriteCount  out  ADDR_WIDTH+1  symbols stored, 0..DEPTH.
- outReadCount  out  log2(DATA_WIDTH)  bit index within head symbol.
- outFull, outEmpty, outAlmostFull, outAlmostEmpty  out  1 each  status flags.
- outWriteError, outReadError  out  1 each  single-cycle error pulses.

## Operation
- Storage: DEPTH × DATA_WIDTH array, write pointer, read pointer (ADDR_WIDTH bits, natural wrap), symbol count (ADDR_WIDTH+1 bits), bit index.
- Write: inWriteEnable && !outFull → store at write pointer, pointer+1, count+1. inWriteEnable && outFull → no store, outWriteError=1 one cycle.
- Read: inReadEnable && !outEmpty → outData = head[bit selected by bit index], outValid=1, bit index+1. On bit index = DATA_WIDTH-1: bit index→0, read pointer+1, count−1, outDone=1.
- inReadEnable && outEmpty → outReadError=1, outValid=0, outData holds.
- Bit order default MSB first: index 0 selects bit DATA_WIDTH-1.
- Simultaneous write and symbol-completing read: both take effect, count unchanged. Full/empty evaluated on pre-edge count: write when full rejected even if the same cycle frees a slot; read when empty errors even if the same cycle writes.
- Flags combinational from count: outEmpty = (count==0), outFull = (count==DEPTH), outAlmostEmpty = (count≤1), outAlmostFull = (count≥DEPTH-1).
- outReadCount = bit index; partial symbol stays at head until its last bit is read.

## Timing
- Reset: pointers, count, bit index, outData, outValid, outDone, both error pulses = 0; outEmpty=1, outAlmostEmpty=1, outFull=0, outAlmostFull=0. Memory contents not cleared.
- Reset mid-symbol discards the partial symbol and all stored symbols.
- Write-to-read latency: symbol written at edge k readable by request sampled at edge k+1.
- Read latency: request sampled at edge k → outData/outValid/outDone valid after edge k for one cycle.
- Counts and flags update at the same edge as the causing operation.
- Back-to-back reads every cycle supported; no bubble between symbols.

## Configuration
- SYMBOL_LSB_FIRST_EN defined: bit index 0 selects bit 0 (LSB first).
- Undefined: MSB first as above. No other behaviour changes.

## Structure
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, DEPTH, BIT_IDX_W = $clog2(DATA_WIDTH) localparams.
- One sub-module natural: symbol_fifo_mem (DEPTH × DATA_WIDTH register array, synchronous write, asynchronous read of head).

## Test plan
- Reset, write 0xA,0xD,0x7,0xF, 16 single reads → bits 1010 1101 0111 1111; outDone on reads 4,8,12,16; outEmpty=1 after.
- Write 5 symbols (DEPTH=4) → fifth gives outWriteError pulse, outWriteCount stays 4, outFull=1; reading yields first four only.
- Read with FIFO empty → outReadError pulse, outValid=0, outData unchanged, counts unchanged.
- Count=1 holding 0x3, 3 bits already read; write 0x5 with the 4th read same cycle → outDone=1, bit 1, outWriteCount stays 1, next 4 reads 0,1,0,1.
- Write 0xC, read 2 bits, assert inReset → all outputs at reset values; new write 0x9 then 4 reads → 1,0,0,1.
- SYMBOL_LSB_FIRST_EN defined: write 0xA, 4 reads → 0,1,0,1.
